seq_pattern_tx: RTL

Serial pattern transmitter: the driving end of the single-bit `din` stream consumed by the 1101 overlapping Mealy sequence detector. It accepts parallel words through a ready/load handshake and shifts them out MSB-first, one bit per clock, with an optional idle gap between words. It also tracks the bits it has sent and emits a reference `exp_det` pulse and a hit count. A bench can compare these cycle-for-cycle against the detector's `dout`.

---
 rtl/seq_pattern_tx_pkg.sv | 15 +
 rtl/seq_pattern_tx_if.sv | 19 +
 rtl/seq_pattern_tx_hist.sv | 35 +++
 rtl/seq_pattern_tx.sv | 96 +++++++++
 4 files changed

// File: rtl/seq_pattern_tx_pkg.sv
// Shared types and constants for the 1101 pattern transmitter and its
// reference hit tracker.
`timescale 1ns/1ps
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } tx_state_t;

    localparam int                 DET_LEN     = 4;
    localparam logic [DET_LEN-1:0] DET_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Load/ready word handshake plus the serial stream and reference-detect outputs.
`timescale 1ns/1ps
interface seq_pattern_tx_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) ();

    logic             load;
    logic [WIDTH-1:0] data;
    logic             ready;
    logic             dout;
    logic             valid;
    logic             exp_det;
    logic [CNT_W-1:0] hit_cnt;

    modport master (output load, data, input ready, dout, valid, exp_det, hit_cnt);
    modport slave  (input load, data, output ready, dout, valid, exp_det, hit_cnt);

endinterface

// File: rtl/seq_pattern_tx_hist.sv
// Shadows the overlapping Mealy detector: keeps the last DET_LEN-1 serial bits,
// flags the bit that completes the pattern and counts those flags.
`timescale 1ns/1ps
module seq_hist_tracker
    import seq_pkg::*;
#(
    parameter int                 CNT_W   = 16,
    parameter logic [DET_LEN-1:0] PATTERN = DET_PATTERN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dout,
    output logic             exp_det,
    output logic [CNT_W-1:0] hit_cnt
);

    logic [DET_LEN-2:0] hist;

    // Mealy view: the current bit completes the match in the same cycle.
    assign exp_det = (dout == PATTERN[0]) && (hist == PATTERN[DET_LEN-1:1]);

    // NOTE: an asynchronous reset belongs in the sensitivity list; state
    // updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist    <= '0;
            hit_cnt <= '0;
        end else begin
            hist <= {hist[DET_LEN-3:0], dout};
            if (exp_det)
                hit_cnt <= hit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts words on load/ready, shifts them out
// MSB-first with an optional idle gap, and drives a reference detect stream.
`timescale 1ns/1ps
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 0,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    seq_pattern_tx_if.slave bus
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    tx_state_t        state;
    logic [WIDTH-1:0] sreg;
    logic [BIT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             dout_q;
    logic             valid_q;
    logic             last_bit;
    logic             last_gap;
    logic             accept;

    assign last_bit  = (state == ST_SHIFT) && (bit_cnt == LAST_BIT);
    assign last_gap  = (state == ST_GAP) && (gap_cnt == LAST_GAP);
    assign bus.ready = (state == ST_IDLE) || (last_bit && (GAP == 0)) || last_gap;
    assign accept    = bus.load && bus.ready;
    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_SHIFT: begin
                    if (!last_bit) begin
                        sreg    <= sreg << 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        dout_q  <= sreg[WIDTH-2];
                    end else if (GAP > 0) begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                        dout_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end else if (!accept) begin
                        state   <= ST_IDLE;
                        dout_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (!last_gap)
                        gap_cnt <= gap_cnt + 1'b1;
                    else if (!accept)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // An accepted word overrides whatever the current state decided.
            if (accept) begin
                state   <= ST_SHIFT;
                sreg    <= bus.data;
                bit_cnt <= '0;
                dout_q  <= bus.data[WIDTH-1];
                valid_q <= 1'b1;
            end
        end
    end

    seq_hist_tracker #(
        .CNT_W  (CNT_W),
        .PATTERN(DET_PATTERN)
    ) u_hist (
        .clk    (clk),
        .reset  (reset),
        .dout   (dout_q),
        .exp_det(bus.exp_det),
        .hit_cnt(bus.hit_cnt)
    );

endmodule
